// File: rtl/dma_cfg_pkg.sv
// ---------------------------------------------------------------------------
// dma_cfg_pkg
// Shared definitions for the DMA configuration scheduler:
//   state_e          - scheduler FSM encoding (IDLE/ISSUE/WAIT/DONE)
//   DIR_S2MM/MM2S    - normalised transfer-direction codes
//   DEFAULT_TIMEOUT  - default WAIT-state watchdog limit in cycles
//   norm_dir()       - folds a raw requester direction onto S2MM/MM2S
// ---------------------------------------------------------------------------
package dma_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] DIR_S2MM = 2'b01;
    localparam logic [1:0] DIR_MM2S = 2'b10;

    localparam int DEFAULT_TIMEOUT = 1024;

    // Only 2'b01 means S2MM; every other code is treated as MM2S, so the
    // engine only ever sees one of the two legal values.
    function automatic logic [1:0] norm_dir(input logic [1:0] d);
        return (d == DIR_S2MM) ? DIR_S2MM : DIR_MM2S;
    endfunction

endpackage

// File: rtl/dma_cfg_scheduler_if.sv
// ---------------------------------------------------------------------------
// dma_cfg_scheduler_if
// Bundles the requester-side job bus and the configuration-engine bus.
//   REQ_*  : per-requester job request (valid/fields in, ready/done/err out),
//            packed arrays with requester 0 at the LSBs
//   CFG_*  : start pulse plus latched job fields to the engine, finish back
// Modports:
//   master - the scheduler
//   slave  - the requesters and the configuration engine
// ---------------------------------------------------------------------------
interface dma_cfg_scheduler_if #(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    import dma_cfg_pkg::*;

    logic [N_REQ-1:0]             REQ_VALID;
    logic [N_REQ-1:0]             REQ_READY;
    logic [N_REQ-1:0][ADDR_W-1:0] REQ_REG_BASE;
    logic [N_REQ-1:0][ADDR_W-1:0] REQ_BUFFER_BASE;
    logic [N_REQ-1:0][1:0]        REQ_DIRECTION;
    logic [N_REQ-1:0][DATA_W-1:0] REQ_LEN;
    logic [N_REQ-1:0]             REQ_DONE;
    logic [N_REQ-1:0]             REQ_ERR;

    logic                         CFG_START;
    logic                         CFG_FINISH;
    logic [ADDR_W-1:0]            CFG_REG_BASE;
    logic [ADDR_W-1:0]            CFG_BUFFER_BASE;
    logic [1:0]                   CFG_DIRECTION;
    logic [DATA_W-1:0]            CFG_TRANSFER_LEN;

    modport master (
        input  REQ_VALID, REQ_REG_BASE, REQ_BUFFER_BASE, REQ_DIRECTION,
               REQ_LEN, CFG_FINISH,
        output REQ_READY, REQ_DONE, REQ_ERR, CFG_START, CFG_REG_BASE,
               CFG_BUFFER_BASE, CFG_DIRECTION, CFG_TRANSFER_LEN
    );

    modport slave (
        output REQ_VALID, REQ_REG_BASE, REQ_BUFFER_BASE, REQ_DIRECTION,
               REQ_LEN, CFG_FINISH,
        input  REQ_READY, REQ_DONE, REQ_ERR, CFG_START, CFG_REG_BASE,
               CFG_BUFFER_BASE, CFG_DIRECTION, CFG_TRANSFER_LEN
    );

endinterface

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick among N_REQ requesters.
//   req        in  N_REQ  request vector
//   last_grant in  IW     previously served requester
//   en         in  1      arbitration allowed this cycle
//   gnt_idx    out IW     chosen requester (0 when none)
//   gnt_vld    out 1      a requester was chosen
// Search starts at last_grant+1 and wraps modulo N_REQ, so the most
// recently served requester has the lowest priority.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_grant,
    input  logic             en,
    output logic [IW-1:0]    gnt_idx,
    output logic             gnt_vld
);

    always_comb begin
        int k;
        k       = 0;
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(last_grant) + i) % N_REQ;
            if (en && !gnt_vld && req[k[IW-1:0]]) begin
                gnt_idx = k[IW-1:0];
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// dma_cfg_scheduler
// Arbitrates DMA configuration jobs from N_REQ requesters and hands one at a
// time to a shared register-configuration engine.
// Ports:
//   M_AXI_ACLK    in   clock
//   M_AXI_ARESET  in   synchronous active-high reset
//   bus           ---  dma_cfg_scheduler_if.master (REQ_* job bus, CFG_* engine bus)
//   BUSY          out  high whenever the FSM is not in IDLE
//   GRANT_ID      out  index of the current / last granted requester
// Flow: IDLE (grant, REQ_READY) -> ISSUE (CFG_START) -> WAIT (CFG_FINISH or
// watchdog) -> DONE (REQ_DONE) -> IDLE. Zero-length jobs are rejected
// straight from IDLE with REQ_ERR.
// ---------------------------------------------------------------------------
module dma_cfg_scheduler
    import dma_cfg_pkg::*;
#(
    parameter  int N_REQ            = 4,
    parameter  int M_AXI_ADDR_WIDTH = 32,
    parameter  int M_AXI_DATA_WIDTH = 32,
    parameter  int TIMEOUT_CYCLES   = DEFAULT_TIMEOUT,  // must be >= 2
    localparam int IW               = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                M_AXI_ACLK,
    input  logic                M_AXI_ARESET,
    dma_cfg_scheduler_if.master bus,
    output logic                BUSY,
    output logic [IW-1:0]       GRANT_ID
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    state_e                        state;
    logic [IW-1:0]                 last_grant;
    logic [IW-1:0]                 grant_id;
    logic [CW-1:0]                 wd_cnt;
    logic                          busy_q;
    logic                          cfg_start_q;
    logic [N_REQ-1:0]              done_q;
    logic [N_REQ-1:0]              err_q;
    logic [M_AXI_ADDR_WIDTH-1:0]   cfg_reg_base_q;
    logic [M_AXI_ADDR_WIDTH-1:0]   cfg_buf_base_q;
    logic [1:0]                    cfg_dir_q;
    logic [M_AXI_DATA_WIDTH-1:0]   cfg_len_q;

    logic                          arb_en;
    logic                          arb_vld;
    logic [IW-1:0]                 arb_idx;
    logic [N_REQ-1:0]              ready;

    // Arbitration is only live in IDLE, and is masked during reset so that
    // the combinational REQ_READY is also 0 while reset is asserted.
    assign arb_en = (state == ST_IDLE) && !M_AXI_ARESET;

    rr_arbiter #(
        .N_REQ      (N_REQ)
    ) u_arb (
        .req        (bus.REQ_VALID),
        .last_grant (last_grant),
        .en         (arb_en),
        .gnt_idx    (arb_idx),
        .gnt_vld    (arb_vld)
    );

    // REQ_READY is the handshake for the grant itself, so it is asserted in
    // the same cycle the requester wins; that is what gives a 1-cycle
    // request-to-CFG_START latency.
    always_comb begin
        ready = '0;
        if (arb_vld) ready[arb_idx] = 1'b1;
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (M_AXI_ARESET) begin
            state          <= ST_IDLE;
            last_grant     <= IW'(N_REQ - 1);
            grant_id       <= '0;
            wd_cnt         <= '0;
            busy_q         <= 1'b0;
            cfg_start_q    <= 1'b0;
            done_q         <= '0;
            err_q          <= '0;
            cfg_reg_base_q <= '0;
            cfg_buf_base_q <= '0;
            cfg_dir_q      <= '0;
            cfg_len_q      <= '0;
        end else begin
            // Pulse outputs default low every cycle.
            cfg_start_q <= 1'b0;
            done_q      <= '0;
            err_q       <= '0;

            case (state)
                ST_IDLE: begin
                    if (arb_vld) begin
                        grant_id       <= arb_idx;
                        cfg_reg_base_q <= bus.REQ_REG_BASE[arb_idx];
                        cfg_buf_base_q <= bus.REQ_BUFFER_BASE[arb_idx];
                        cfg_dir_q      <= norm_dir(bus.REQ_DIRECTION[arb_idx]);
                        cfg_len_q      <= bus.REQ_LEN[arb_idx];
                        if (bus.REQ_LEN[arb_idx] == '0) begin
                            // Rejected without touching the engine; the
                            // pointer still advances so the requester does
                            // not starve the others by retrying.
                            err_q[arb_idx] <= 1'b1;
                            last_grant     <= arb_idx;
                        end else begin
                            state       <= ST_ISSUE;
                            busy_q      <= 1'b1;
                            cfg_start_q <= 1'b1;
                        end
                    end
                end

                ST_ISSUE: begin
                    state  <= ST_WAIT;
                    wd_cnt <= '0;
                end

                ST_WAIT: begin
                    // Finish is checked first so it wins over a timeout
                    // landing in the same cycle.
                    if (bus.CFG_FINISH) begin
                        state            <= ST_DONE;
                        done_q[grant_id] <= 1'b1;
                    end else if (wd_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        state           <= ST_IDLE;
                        busy_q          <= 1'b0;
                        err_q[grant_id] <= 1'b1;
                        last_grant      <= grant_id;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end

                ST_DONE: begin
                    state      <= ST_IDLE;
                    busy_q     <= 1'b0;
                    last_grant <= grant_id;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.REQ_READY        = ready;
    assign bus.REQ_DONE         = done_q;
    assign bus.REQ_ERR          = err_q;
    assign bus.CFG_START        = cfg_start_q;
    assign bus.CFG_REG_BASE     = cfg_reg_base_q;
    assign bus.CFG_BUFFER_BASE  = cfg_buf_base_q;
    assign bus.CFG_DIRECTION    = cfg_dir_q;
    assign bus.CFG_TRANSFER_LEN = cfg_len_q;
    assign BUSY                 = busy_q;
    assign GRANT_ID             = grant_id;

endmodule

// File: tb/tb_dma_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_dma_cfg_scheduler
// Directed tests for dma_cfg_scheduler (N_REQ=4, TIMEOUT_CYCLES=16).
// Inputs change #1 after posedge; outputs are observed on negedge.
// A small engine model raises CFG_FINISH fin_delay cycles after CFG_START
// (never when fin_delay < 0).
// ---------------------------------------------------------------------------
module tb_dma_cfg_scheduler;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       busy;
    logic [1:0] gid;
    logic       fin_eng   = 1'b0;
    logic       fin_force = 1'b0;
    int         fin_delay = -1;

    int n_tests = 0;
    int n_fail  = 0;

    dma_cfg_scheduler_if #(.N_REQ(N), .ADDR_W(32), .DATA_W(32)) bus ();

    dma_cfg_scheduler #(
        .N_REQ            (N),
        .M_AXI_ADDR_WIDTH (32),
        .M_AXI_DATA_WIDTH (32),
        .TIMEOUT_CYCLES   (16)
    ) dut (
        .M_AXI_ACLK   (clk),
        .M_AXI_ARESET (rst),
        .bus          (bus.master),
        .BUSY         (busy),
        .GRANT_ID     (gid)
    );

    assign bus.CFG_FINISH = fin_eng | fin_force;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- monitor ----------------
    int cyc = 0, rdy_cnt = 0, rdy_cyc = 0, rdy_busy = 0, start_cnt = 0, start_cyc = 0;
    int done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0, multi = 0;
    logic [N-1:0] done_vec = '0, err_vec = '0;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.REQ_READY != 0) begin
            rdy_cnt = rdy_cnt + 1;
            rdy_cyc = cyc;
            if (busy) rdy_busy = rdy_busy + 1;
        end
        if (bus.CFG_START) begin start_cnt = start_cnt + 1; start_cyc = cyc; end
        if (bus.REQ_DONE != 0) begin done_cnt = done_cnt + 1; done_cyc = cyc; done_vec = bus.REQ_DONE; end
        if (bus.REQ_ERR != 0) begin err_cnt = err_cnt + 1; err_cyc = cyc; err_vec = bus.REQ_ERR; end
        if (!$onehot0(bus.REQ_READY) || !$onehot0(bus.REQ_DONE) || !$onehot0(bus.REQ_ERR))
            multi = multi + 1;
    end

    // ---------------- engine model ----------------
    always begin
        @(posedge clk); #1;
        if (bus.CFG_START === 1'b1 && fin_delay > 0) begin
            repeat (fin_delay) begin @(posedge clk); #1; end
            fin_eng = 1'b1;
            @(posedge clk); #1;
            fin_eng = 1'b0;
        end
    end

    function automatic int idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    task automatic clear_inputs();
        bus.REQ_VALID       = '0;
        bus.REQ_REG_BASE    = '0;
        bus.REQ_BUFFER_BASE = '0;
        bus.REQ_DIRECTION   = '0;
        bus.REQ_LEN         = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; clear_inputs(); fin_force = 1'b0; fin_delay = -1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.REQ_VALID = 4'b0001; bus.REQ_LEN[0] = 32'h8;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_tests++;
        if ({busy, bus.CFG_START, bus.REQ_READY, bus.REQ_DONE, bus.REQ_ERR, gid} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: busy=%b start=%b rdy=%b done=%b err=%b gid=%0d, all required 0",
                     busy, bus.CFG_START, bus.REQ_READY, bus.REQ_DONE, bus.REQ_ERR, gid);
        end
        n_tests++;
        if ({bus.CFG_REG_BASE, bus.CFG_BUFFER_BASE, bus.CFG_DIRECTION, bus.CFG_TRANSFER_LEN} !== '0) begin
            n_fail++;
            $display("FAIL reset_cfg: reg=%h buf=%h dir=%b len=%h, all required 0",
                     bus.CFG_REG_BASE, bus.CFG_BUFFER_BASE, bus.CFG_DIRECTION, bus.CFG_TRANSFER_LEN);
        end
        @(posedge clk); #1;
        clear_inputs(); rst = 1'b0;
    endtask

    task automatic test_single_job();
        int s0, r0, e0; bit hit;
        s0 = start_cnt; r0 = rdy_cnt; e0 = err_cnt;
        fin_delay = 10;
        @(posedge clk); #1;
        bus.REQ_REG_BASE[2] = 32'hA000_0200; bus.REQ_BUFFER_BASE[2] = 32'h1000_0000;
        bus.REQ_DIRECTION[2] = 2'b01; bus.REQ_LEN[2] = 32'h400; bus.REQ_VALID[2] = 1'b1;
        hit = 0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.REQ_READY[2]) begin hit = 1; break; end end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL single_ready: REQ_READY=%b, required bit 2 within 8 cycles", bus.REQ_READY); end
        @(posedge clk); #1;
        bus.REQ_VALID = '0;
        n_tests++;
        if ({bus.CFG_START, busy, gid} !== {1'b1, 1'b1, 2'd2}) begin
            n_fail++; $display("FAIL single_issue: start=%b busy=%b gid=%0d, required 1 1 2", bus.CFG_START, busy, gid);
        end
        n_tests++;
        if (bus.CFG_REG_BASE !== 32'hA000_0200 || bus.CFG_BUFFER_BASE !== 32'h1000_0000 ||
            bus.CFG_DIRECTION !== 2'b01 || bus.CFG_TRANSFER_LEN !== 32'h400) begin
            n_fail++; $display("FAIL single_fields: reg=%h buf=%h dir=%b len=%h, required a0000200 10000000 01 400",
                               bus.CFG_REG_BASE, bus.CFG_BUFFER_BASE, bus.CFG_DIRECTION, bus.CFG_TRANSFER_LEN);
        end
        hit = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus.REQ_DONE != 0) begin hit = 1; break; end end
        #1;
        n_tests++;
        if (!hit || done_vec !== 4'b0100) begin n_fail++; $display("FAIL single_done: done=%b, required 0100", done_vec); end
        n_tests++;
        if (done_cyc - start_cyc != 11) begin n_fail++; $display("FAIL single_done_time: %0d cycles after start, required 11", done_cyc - start_cyc); end
        n_tests++;
        if (start_cyc - rdy_cyc != 1) begin n_fail++; $display("FAIL single_latency: %0d cycles ready->start, required 1", start_cyc - rdy_cyc); end
        repeat (2) @(posedge clk); #1;
        n_tests++;
        if (start_cnt - s0 != 1 || rdy_cnt - r0 != 1 || err_cnt != e0) begin
            n_fail++; $display("FAIL single_counts: starts=%0d readys=%0d errs=%0d, required 1 1 0",
                               start_cnt - s0, rdy_cnt - r0, err_cnt - e0);
        end
        n_tests++;
        if (busy !== 1'b0 || gid !== 2'd2 || bus.CFG_REG_BASE !== 32'hA000_0200) begin
            n_fail++; $display("FAIL single_hold: busy=%b gid=%0d reg=%h, required 0 2 a0000200", busy, gid, bus.CFG_REG_BASE);
        end
    endtask

    task automatic test_zero_len();
        int s0; bit hit;
        s0 = start_cnt;
        @(posedge clk); #1;
        bus.REQ_LEN[1] = 32'h0; bus.REQ_VALID[1] = 1'b1;
        hit = 0;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.REQ_READY[1]) begin hit = 1; break; end end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL zero_ready: REQ_READY=%b, required bit 1", bus.REQ_READY); end
        @(posedge clk); #1;
        bus.REQ_VALID = '0;
        @(negedge clk);
        n_tests++;
        if ({bus.REQ_ERR, bus.CFG_START, busy, gid} !== {4'b0010, 1'b0, 1'b0, 2'd1}) begin
            n_fail++; $display("FAIL zero_err: err=%b start=%b busy=%b gid=%0d, required 0010 0 0 1",
                               bus.REQ_ERR, bus.CFG_START, busy, gid);
        end
        #1;
        n_tests++;
        if (err_cyc != rdy_cyc + 1) begin n_fail++; $display("FAIL zero_err_time: err %0d cycles after ready, required 1", err_cyc - rdy_cyc); end
        repeat (3) @(posedge clk); #1;
        n_tests++;
        if (start_cnt != s0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL zero_no_start: starts=%0d busy=%b, required 0 0", start_cnt - s0, busy);
        end
    endtask

    task automatic test_stray_finish();
        int d0; bit hit;
        d0 = done_cnt;
        @(posedge clk); #1;
        fin_force = 1'b1;
        @(posedge clk); #1;
        fin_force = 1'b0;
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || done_cnt != d0) begin
            n_fail++; $display("FAIL stray_idle: busy=%b dones=%0d, required 0 0", busy, done_cnt - d0);
        end
        fin_delay = 3;
        @(posedge clk); #1;
        bus.REQ_LEN[0] = 32'h8; bus.REQ_DIRECTION[0] = 2'b11; bus.REQ_VALID[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.REQ_READY[0]) break; end
        @(posedge clk); #1;
        bus.REQ_VALID = '0; fin_force = 1'b1;  // finish during ISSUE must be ignored
        n_tests++;
        if (bus.CFG_DIRECTION !== 2'b10) begin n_fail++; $display("FAIL stray_dir: dir=%b for raw 11, required 10", bus.CFG_DIRECTION); end
        @(posedge clk); #1;
        fin_force = 1'b0;
        hit = 0;
        for (int i = 0; i < 30; i++) begin @(negedge clk); if (bus.REQ_DONE != 0) begin hit = 1; break; end end
        #1;
        n_tests++;
        if (!hit || done_vec !== 4'b0001 || done_cyc - start_cyc != 4) begin
            n_fail++; $display("FAIL stray_issue: done=%b at %0d cycles after start, required 0001 at 4",
                               done_vec, done_cyc - start_cyc);
        end
        repeat (2) @(posedge clk); #1;
    endtask

    task automatic test_fairness();
        int order[8]; int at[8]; int n, rb0;
        rb0 = rdy_busy; fin_delay = 2; n = 0;
        @(posedge clk); #1;
        for (int r = 0; r < N; r++) begin bus.REQ_LEN[r] = 32'h100 * (r + 1); bus.REQ_DIRECTION[r] = r[1:0]; end
        bus.REQ_VALID = 4'hF;
        for (int i = 0; i < 200 && n < 8; i++) begin
            @(negedge clk);
            if (bus.REQ_READY != 0) begin order[n] = idx(bus.REQ_READY); at[n] = i; n++; end
        end
        @(posedge clk); #1;
        bus.REQ_VALID = '0;
        repeat (8) @(posedge clk); #1;
        n_tests++;
        if (n != 8) begin n_fail++; $display("FAIL fair_count: %0d grants seen, required 8", n); end
        for (int j = 0; j < 8; j++) begin
            n_tests++;
            if (order[j] != j % 4) begin n_fail++; $display("FAIL fair_order[%0d]: granted %0d, required %0d", j, order[j], j % 4); end
        end
        n_tests++;
        if (at[1] - at[0] != 5) begin n_fail++; $display("FAIL fair_rate: %0d cycles between grants, required 5", at[1] - at[0]); end
        n_tests++;
        if (rdy_busy != rb0) begin n_fail++; $display("FAIL fair_ready_busy: %0d readies while busy, required 0", rdy_busy - rb0); end
    endtask

    task automatic test_timeout();
        int d0; bit hit;
        d0 = done_cnt; fin_delay = -1;
        @(posedge clk); #1;
        bus.REQ_LEN[1] = 32'h80; bus.REQ_DIRECTION[1] = 2'b00; bus.REQ_VALID[1] = 1'b1;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.REQ_READY[1]) break; end
        @(posedge clk); #1;
        bus.REQ_VALID = '0;
        n_tests++;
        if ({bus.CFG_START, gid, bus.CFG_DIRECTION} !== {1'b1, 2'd1, 2'b10}) begin
            n_fail++; $display("FAIL tmo_issue: start=%b gid=%0d dir=%b, required 1 1 10", bus.CFG_START, gid, bus.CFG_DIRECTION);
        end
        hit = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus.REQ_ERR != 0) begin hit = 1; break; end end
        n_tests++;
        if (!hit || busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: err seen=%0d busy=%b, required 1 0", hit, busy); end
        #1;
        n_tests++;
        if (err_vec !== 4'b0010 || err_cyc - start_cyc != 17) begin
            n_fail++; $display("FAIL tmo_err: err=%b at %0d cycles after start, required 0010 at 17", err_vec, err_cyc - start_cyc);
        end
        n_tests++;
        if (done_cnt != d0) begin n_fail++; $display("FAIL tmo_no_done: %0d dones, required 0", done_cnt - d0); end
        @(posedge clk); #1;
        bus.REQ_LEN = '0; bus.REQ_VALID = 4'hF;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.REQ_READY != 0) break; end
        n_tests++;
        if (bus.REQ_READY !== 4'b0100) begin n_fail++; $display("FAIL tmo_next: ready=%b, required 0100", bus.REQ_READY); end
        @(posedge clk); #1;
        bus.REQ_VALID = '0;
        repeat (3) @(posedge clk); #1;
    endtask

    task automatic test_finish_on_timeout();
        int e0; bit hit;
        e0 = err_cnt; fin_delay = 16;
        @(posedge clk); #1;
        bus.REQ_LEN[0] = 32'h10; bus.REQ_VALID[0] = 1'b1;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.REQ_READY[0]) break; end
        @(posedge clk); #1;
        bus.REQ_VALID = '0;
        hit = 0;
        for (int i = 0; i < 40; i++) begin @(negedge clk); if (bus.REQ_DONE != 0 || bus.REQ_ERR != 0) begin hit = 1; break; end end
        repeat (2) @(posedge clk); #1;
        n_tests++;
        if (!hit || done_vec !== 4'b0001 || done_cyc - start_cyc != 17) begin
            n_fail++; $display("FAIL race_done: done=%b at %0d cycles after start, required 0001 at 17", done_vec, done_cyc - start_cyc);
        end
        n_tests++;
        if (err_cnt != e0) begin n_fail++; $display("FAIL race_no_err: %0d errs, required 0", err_cnt - e0); end
    endtask

    task automatic test_reset_during_wait();
        int d0, e0;
        fin_delay = -1;
        @(posedge clk); #1;
        bus.REQ_REG_BASE[3] = 32'hDEAD_0000; bus.REQ_LEN[3] = 32'h20; bus.REQ_VALID[3] = 1'b1;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.REQ_READY[3]) break; end
        @(posedge clk); #1;
        bus.REQ_VALID = '0;
        repeat (4) @(posedge clk); #1;
        n_tests++;
        if (busy !== 1'b1 || gid !== 2'd3) begin n_fail++; $display("FAIL rstw_busy: busy=%b gid=%0d, required 1 3", busy, gid); end
        d0 = done_cnt; e0 = err_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({busy, bus.CFG_START, bus.REQ_READY, bus.REQ_DONE, bus.REQ_ERR, gid} !== 16'h0 ||
            {bus.CFG_REG_BASE, bus.CFG_BUFFER_BASE, bus.CFG_DIRECTION, bus.CFG_TRANSFER_LEN} !== '0) begin
            n_fail++; $display("FAIL rstw_outputs: busy=%b gid=%0d reg=%h len=%h, all required 0",
                               busy, gid, bus.CFG_REG_BASE, bus.CFG_TRANSFER_LEN);
        end
        rst = 1'b0;
        repeat (25) @(posedge clk); #1;
        n_tests++;
        if (done_cnt != d0 || err_cnt != e0) begin
            n_fail++; $display("FAIL rstw_no_pulse: dones=%0d errs=%0d, required 0 0", done_cnt - d0, err_cnt - e0);
        end
        bus.REQ_LEN = '0; bus.REQ_VALID = 4'b1011;
        for (int i = 0; i < 8; i++) begin @(negedge clk); if (bus.REQ_READY != 0) break; end
        n_tests++;
        if (bus.REQ_READY !== 4'b0001) begin n_fail++; $display("FAIL rstw_next: ready=%b, required 0001", bus.REQ_READY); end
        @(posedge clk); #1;
        bus.REQ_VALID = '0;
        repeat (3) @(posedge clk); #1;
        n_tests++;
        if (multi != 0) begin n_fail++; $display("FAIL onehot: %0d cycles with more than one pulse bit, required 0", multi); end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_single_job();
        test_zero_len();
        test_stray_finish();
        do_reset();
        test_fairness();
        test_timeout();
        test_finish_on_timeout();
        test_reset_during_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dma_cfg_scheduler.md
DMA_CFG_SCHEDULER -- requirements
Module: dma_cfg_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4, giving the number of requesters.
REQ-002 SHALL have parameter M_AXI_ADDR_WIDTH, default 32, giving the address width.
REQ-003 SHALL have parameter M_AXI_DATA_WIDTH, default 32, giving the length width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, the WAIT-state watchdog limit, with a minimum of 2.
REQ-005 SHALL have port M_AXI_ACLK  in  1  the single clock.
REQ-006 SHALL have port M_AXI_ARESET  in  1  reset, synchronous and active-high.
REQ-007 SHALL have port REQ_VALID  in  N_REQ  per-requester job valid.
REQ-008 SHALL have port REQ_READY  out  N_REQ  per-requester job accepted, a 1-cycle pulse.
REQ-009 SHALL have port REQ_REG_BASE  in  N_REQ*ADDR  per-requester DMA register base, packed with requester 0 at the LSBs.
REQ-010 SHALL have port REQ_BUFFER_BASE  in  N_REQ*ADDR  per-requester buffer address.
REQ-011 SHALL have port REQ_DIRECTION  in  N_REQ*2  per-requester direction, where 2'b01 = S2MM and any other value = MM2S.
REQ-012 SHALL have port REQ_LEN  in  N_REQ*DATA  per-requester byte length.
REQ-013 SHALL have port REQ_DONE  out  N_REQ  job completed, a 1-cycle pulse.
REQ-014 SHALL have port REQ_ERR  out  N_REQ  job rejected or timed out, a 1-cycle pulse.
REQ-015 SHALL have port CFG_START  out  1  start pulse to the DMA register-configuration engine.
REQ-016 SHALL have port CFG_FINISH  in  1  engine finished, a 1-cycle pulse.
REQ-017 SHALL have ports CFG_REG_BASE, CFG_BUFFER_BASE, CFG_DIRECTION and CFG_TRANSFER_LEN  out  ADDR, ADDR, 2 and DATA  the latched job fields.
REQ-018 SHALL have port BUSY  out  1  high in every state except IDLE.
REQ-019 SHALL have port GRANT_ID  out  clog2(N_REQ)  index of the current or last granted requester.

Function
REQ-020 SHALL implement the FSM states IDLE, ISSUE, WAIT and DONE.
REQ-021 IDLE: when any REQ_VALID is high, SHALL grant exactly one requester round-robin, searching from last_grant+1 modulo N_REQ.
REQ-022 On a grant, SHALL pulse REQ_READY[g] in that cycle and latch g and that requester's fields into the CFG_* registers on the same edge.
REQ-023 A granted job with REQ_LEN==0 SHALL NOT issue; REQ_ERR[g] SHALL pulse the next cycle and the FSM SHALL stay in IDLE; last_grant SHALL still update.
REQ-024 A nonzero-length grant SHALL go IDLE->ISSUE, and CFG_START SHALL be high for exactly the one ISSUE cycle.
REQ-025 ISSUE->WAIT SHALL be unconditional, and SHALL clear the watchdog counter.
REQ-026 WAIT: CFG_FINISH SHALL move the FSM to DONE; otherwise the counter SHALL increment, and when it equals TIMEOUT_CYCLES-1 the FSM SHALL pulse REQ_ERR[g] and go to IDLE.
REQ-027 When CFG_FINISH and the timeout occur in the same cycle, FINISH SHALL win.
REQ-028 DONE: SHALL pulse REQ_DONE[g] for one cycle, update last_grant=g, then go to IDLE.
REQ-029 A timeout SHALL also update last_grant=g.
REQ-030 The CFG_* fields SHALL be held stable from the grant edge until the next grant, because the engine samples them one cycle after CFG_START.
REQ-031 CFG_FINISH outside WAIT SHALL be ignored.
REQ-032 REQ_VALID changes after a grant SHALL NOT affect the job in flight; a requester whose REQ_VALID stays high is re-arbitrated normally.
REQ-033 Minimum request-to-CFG_START latency SHALL be 1 cycle, and idle back-to-back throughput SHALL be one job per (3 + engine latency) cycles.
REQ-034 At most one REQ_READY, REQ_DONE or REQ_ERR bit SHALL be high in any cycle.

Reset
REQ-035 On M_AXI_ARESET, sampled at the clock edge, SHALL set state=IDLE, all outputs 0, last_grant=N_REQ-1 (so requester 0 has first priority), and the counter to 0.
REQ-036 A reset during ISSUE or WAIT SHALL abandon the job with no REQ_DONE or REQ_ERR pulse.

Structure
REQ-037 SHALL place the state encoding, the direction constants (S2MM=2'b01, MM2S=2'b10) and the default timeout in the shared package dma_cfg_pkg.
REQ-038 SHALL place the round-robin grant logic in the sub-module rr_arbiter, which takes request, last_grant and enable and returns a grant index and a valid flag.

Verification
REQ-039 Single job: after reset, REQ_VALID[2]=1, len=0x400, dir=01, FINISH 10 cycles after CFG_START -> REQ_READY[2] once, CFG_START once, REQ_DONE[2] pulses, and GRANT_ID=2.
REQ-040 Fairness: all four REQ_VALID held high for 8 jobs -> grant order 0,1,2,3,0,1,2,3, with no REQ_READY while BUSY.
REQ-041 Zero length: REQ_VALID[1]=1 with len=0 -> REQ_READY[1], then REQ_ERR[1] next cycle, no CFG_START, and BUSY stays 0.
REQ-042 Timeout: TIMEOUT_CYCLES=16 and FINISH never arrives -> REQ_ERR[g] exactly 16 cycles after entering WAIT, then IDLE, and the next grant is g+1.
REQ-043 FINISH on the timeout cycle -> REQ_DONE, no REQ_ERR.
REQ-044 Reset during WAIT -> all outputs 0 next cycle, no completion pulse, and the next grant goes to requester 0.
